// File: rtl/mna_response_flit_parser.sv
// Turns header/tail NoC response flits into AXI4-Lite R or B channel beats.
// Optional malformed-flit counter: define MNA_RSP_ERR_CNT_EN to build it.
module mna_response_flit_parser #(
    parameter logic [2:0] LOCAL_VC = 3'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [33:0] flit_in,
    input  logic        flit_valid,
    output logic        flit_ready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    output logic [3:0]  src_addr,
    output logic [7:0]  err_cnt
);
    typedef enum logic [1:0] {IDLE, WAIT_TAIL, SEND_R, SEND_B} state_t;

    state_t      state_q, state_d;
    logic        rvalid_q, rvalid_d;
    logic        bvalid_q, bvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [3:0]  src_addr_q, src_addr_d;
    logic        is_read_q, is_read_d;

    logic fire, is_hdr, is_tail, vc_ok;

    assign flit_ready = (state_q == IDLE) || (state_q == WAIT_TAIL);
    assign fire       = flit_valid && flit_ready;
    assign is_hdr     = (flit_in[33:32] == 2'b10);
    assign is_tail    = (flit_in[33:32] == 2'b01);
    assign vc_ok      = (flit_in[31:29] == LOCAL_VC);

    always_comb begin
        state_d    = state_q;
        rvalid_d   = rvalid_q;
        bvalid_d   = bvalid_q;
        rdata_d    = rdata_q;
        bresp_d    = bresp_q;
        src_addr_d = src_addr_q;
        is_read_d  = is_read_q;
        case (state_q)
            IDLE: begin
                if (fire && is_hdr && vc_ok) begin
                    src_addr_d = flit_in[28:25];
                    is_read_d  = flit_in[0];
                    state_d    = WAIT_TAIL;
                end
            end
            WAIT_TAIL: begin
                if (fire && is_tail) begin
                    if (is_read_q) begin
                        rdata_d  = flit_in[31:0];
                        rvalid_d = 1'b1;
                        state_d  = SEND_R;
                    end else begin
                        bresp_d  = flit_in[1:0];
                        bvalid_d = 1'b1;
                        state_d  = SEND_B;
                    end
                end else if (fire && is_hdr) begin
                    // A new header restarts the packet; a foreign VC abandons it.
                    if (vc_ok) begin
                        src_addr_d = flit_in[28:25];
                        is_read_d  = flit_in[0];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            SEND_R: begin
                if (rready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            SEND_B: begin
                if (bready) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rvalid_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            rdata_q    <= 32'h0;
            bresp_q    <= 2'b00;
            src_addr_q <= 4'h0;
            is_read_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rvalid_q   <= rvalid_d;
            bvalid_q   <= bvalid_d;
            rdata_q    <= rdata_d;
            bresp_q    <= bresp_d;
            src_addr_q <= src_addr_d;
            is_read_q  <= is_read_d;
        end
    end

    assign rvalid   = rvalid_q;
    assign bvalid   = bvalid_q;
    assign rdata    = rdata_q;
    assign rresp    = 2'b00;
    assign bresp    = bresp_q;
    assign src_addr = src_addr_q;

`ifdef MNA_RSP_ERR_CNT_EN
    logic [1:0] err_inc;
    logic [8:0] err_sum;
    logic [7:0] err_cnt_q, err_cnt_d;

    // A foreign-VC header in WAIT_TAIL is two events: lost packet plus bad VC.
    always_comb begin
        err_inc = 2'd0;
        if (fire) begin
            if (state_q == IDLE) begin
                err_inc = (is_hdr && vc_ok) ? 2'd0 : 2'd1;
            end else if (is_hdr) begin
                err_inc = vc_ok ? 2'd1 : 2'd2;
            end else if (!is_tail) begin
                err_inc = 2'd1;
            end
        end
        err_sum   = {1'b0, err_cnt_q} + {7'b0, err_inc};
        err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'h00;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif
endmodule

// File: doc/mna_response_flit_parser.md
MNA_RESPONSE_FLIT_PARSER -- requirements
Module: mna_response_flit_parser

Interface
REQ-001 The block SHALL have parameter LOCAL_VC, default 3'd0, meaning the VC/route ID that header bits [31:29] must match for the packet to be accepted.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have port flit_in, input, 34, the NoC flit: [33:32]=2'b10 header, 2'b01 tail; header [31:29] VC ID, [28:25] source address, [0] 1=read response, 0=write response; tail [31:0] payload.
REQ-005 The block SHALL have port flit_valid, input, 1, flit_in holds a flit.
REQ-006 The block SHALL have port flit_ready, output, 1, a flit is consumed on a cycle with flit_valid and flit_ready both high.
REQ-007 The block SHALL have ports rdata (output, 32), rresp (output, 2), rvalid (output, 1) and rready (input, 1), the AXI4-Lite read-response channel.
REQ-008 The block SHALL have ports bresp (output, 2), bvalid (output, 1) and bready (input, 1), the AXI4-Lite write-response channel.
REQ-009 The block SHALL have port src_addr, output, 4, the source address of the response currently presented.
REQ-010 The block SHALL have port err_cnt, output, 8, the malformed-flit count.

Function
REQ-011 The FSM SHALL have four states: IDLE, WAIT_TAIL, SEND_R and SEND_B.
REQ-012 flit_ready SHALL be high only in IDLE and WAIT_TAIL.
REQ-013 In IDLE, a consumed header with [31:29]==LOCAL_VC SHALL latch src_addr from [28:25] and the read/write flag from [0], then go to WAIT_TAIL.
REQ-014 In IDLE, a consumed header with a mismatching VC SHALL be dropped, raise an error event and stay in IDLE.
REQ-015 In IDLE, a consumed tail or a flit with type 2'b00 or 2'b11 SHALL be dropped, raise an error event and stay in IDLE.
REQ-016 In WAIT_TAIL, a consumed tail SHALL latch payload [31:0]; flag=1 goes to SEND_R (rdata=payload, rresp=2'b00); flag=0 goes to SEND_B (bresp=payload[1:0]).
REQ-017 In WAIT_TAIL, a consumed header SHALL raise an error event, discard the pending packet and be processed as if received in IDLE, including the VC check.
REQ-018 In WAIT_TAIL, a consumed flit of type 00 or 11 SHALL raise an error event, be dropped, and leave the state in WAIT_TAIL.
REQ-019 Latency: a tail consumed at edge N SHALL drive rvalid or bvalid high from edge N onward, i.e. visible in cycle N+1.
REQ-020 rvalid SHALL be high exactly in SEND_R and bvalid exactly in SEND_B, both registered outputs.
REQ-021 rdata, rresp, bresp and src_addr SHALL stay stable while the corresponding valid is high.
REQ-022 SEND_R SHALL go to IDLE on the edge where rready=1; SEND_B SHALL go to IDLE on the edge where bready=1.
REQ-023 rready or bready held high beforehand SHALL give a one-cycle valid pulse.
REQ-024 The minimum packet-to-packet spacing SHALL be 3 cycles: header, tail, response handshake.
REQ-025 rready and bready SHALL be ignored outside their own SEND state.
REQ-026 rvalid and bvalid SHALL never be high simultaneously.

Reset
REQ-027 When rst_n is low, the state SHALL be IDLE; flit_ready SHALL be 1 (combinational from state); rvalid, bvalid, rdata, rresp, bresp, src_addr and err_cnt SHALL be 0.
REQ-028 Reset asserted mid-packet or mid-handshake SHALL drop the packet with no valid re-assertion after release.

Configuration
REQ-029 With MNA_RSP_ERR_CNT_EN defined, err_cnt SHALL be an 8-bit counter incremented once per error event, saturating at 8'hFF.
REQ-030 Without MNA_RSP_ERR_CNT_EN, err_cnt SHALL be constant 0, no counter logic SHALL exist, and error events SHALL only drop flits.

Verification
REQ-031 Header 34'h2_0A00_0001 (VC 0, src 5, read), then tail 34'h1_DEAD_BEEF, rready=1 SHALL give rvalid for one cycle, rdata=32'hDEADBEEF, rresp=0, src_addr=5.
REQ-032 Header with bit0=0, then tail 34'h1_0000_0002, bready held low 4 cycles SHALL hold bvalid=1, bresp=2'b10 stable and flit_ready=0 until bready rises, then return to IDLE.
REQ-033 Tail in IDLE, then header, then tail SHALL drop the first tail, set err_cnt=1 (macro on) and deliver one response.
REQ-034 Header, header, tail SHALL set err_cnt=1 and deliver a response carrying the second header's src_addr and flag.
REQ-035 Header with [31:29]=3'd3 when LOCAL_VC=0, then tail SHALL give no response and err_cnt=2.
REQ-036 rst_n pulsed low during SEND_R SHALL drop rvalid immediately; 300 tails in IDLE then SHALL leave err_cnt=8'hFF (macro on) or 0 (macro off).
